// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Resolves the ALU A/B operands from register read data, an instruction
// immediate or the forwarded ALU result, and holds them in a two-entry skid
// buffer. The buffer has a main output register and one skid register.
//
// Optional feature macro: ALU_OPERAND_FWD_EN
//   defined   : a_sel=1 and b_sel=11 select fwd_data
//   undefined : fwd_data is ignored, a_sel acts as 0, b_sel=11 acts as 10
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous discard of both held entries
//   in_valid   in   upstream request valid
//   in_ready   out  registered; high while the skid register is empty
//   rd_q       in   [DW]  A source (destination register read data)
//   rs_q       in   [DW]  source register read data
//   offset     in   [IMW] instruction immediate
//   b_sel      in   [2]   00 zext(offset), 01 sext(offset), 10 rs_q, 11 fwd_data
//   a_sel      in   1     0 rd_q, 1 fwd_data
//   fwd_data   in   [DW]  forwarded ALU result
//   alu_a      out  [DW]  registered A operand (holds while out_valid=0)
//   alu_b      out  [DW]  registered B operand (holds while out_valid=0)
//   out_valid  out  main register holds an entry
//   out_ready  in   ALU consumes the operands this cycle
//   occupancy  out  [2]   number of full registers, 0..2
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DW  = 16,
    parameter int IMW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  rd_q,
    input  logic [DW-1:0]  rs_q,
    input  logic [IMW-1:0] offset,
    input  logic [1:0]     b_sel,
    input  logic           a_sel,
    input  logic [DW-1:0]  fwd_data,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     occupancy
);

    // ------------------------------------------------------------------
    // Immediate extension. Bits below IMW come from the offset; bits at or
    // above IMW are zero or the offset sign bit. With IMW == DW the upper
    // branch never elaborates, so both forms are the identity.
    // ------------------------------------------------------------------
    logic [DW-1:0] zext_offset;
    logic [DW-1:0] sext_offset;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_ext
            if (gi < IMW) begin : g_low
                assign zext_offset[gi] = offset[gi];
                assign sext_offset[gi] = offset[gi];
            end else begin : g_high
                assign zext_offset[gi] = 1'b0;
                assign sext_offset[gi] = offset[IMW-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand source selection
    // ------------------------------------------------------------------
    logic [DW-1:0] new_a;
    logic [DW-1:0] new_b;

`ifdef ALU_OPERAND_FWD_EN
    always_comb begin
        new_a = a_sel ? fwd_data : rd_q;
        new_b = rs_q;
        case (b_sel)
            2'b00:   new_b = zext_offset;
            2'b01:   new_b = sext_offset;
            2'b10:   new_b = rs_q;
            default: new_b = fwd_data;
        endcase
    end
`else
    // Forwarding path absent: fold the unused inputs into a sink so they are
    // visibly intentional.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_data, a_sel};

    always_comb begin
        new_a = rd_q;
        new_b = rs_q;
        case (b_sel)
            2'b00:   new_b = zext_offset;
            2'b01:   new_b = sext_offset;
            default: new_b = rs_q;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Skid buffer state
    // ------------------------------------------------------------------
    logic          main_valid_reg, main_valid_next;
    logic [DW-1:0] main_a_reg,     main_a_next;
    logic [DW-1:0] main_b_reg,     main_b_next;
    logic          skid_valid_reg, skid_valid_next;
    logic [DW-1:0] skid_a_reg,     skid_a_next;
    logic [DW-1:0] skid_b_reg,     skid_b_next;
    logic          in_ready_reg;

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = in_valid && in_ready_reg;
    assign xfer_out = main_valid_reg && out_ready;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_a_next     = main_a_reg;
        main_b_next     = main_b_reg;
        skid_valid_next = skid_valid_reg;
        skid_a_next     = skid_a_reg;
        skid_b_next     = skid_b_reg;

        if (!main_valid_reg || xfer_out) begin
            // Main register is free after this edge. The skid register can
            // only be full while main is full, and in_ready is low then, so
            // a refill from skid never coincides with an accepted request.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_a_next     = skid_a_reg;
                main_b_next     = skid_b_reg;
                skid_valid_next = 1'b0;
            end else if (xfer_in) begin
                main_valid_next = 1'b1;
                main_a_next     = new_a;
                main_b_next     = new_b;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (xfer_in) begin
            // Main is stalled: park the new entry in the skid register.
            skid_valid_next = 1'b1;
            skid_a_next     = new_a;
            skid_b_next     = new_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_a_reg     <= '0;
            main_b_reg     <= '0;
            skid_valid_reg <= 1'b0;
            skid_a_reg     <= '0;
            skid_b_reg     <= '0;
            in_ready_reg   <= 1'b1;
        end else if (flush) begin
            // Operand registers keep their last values; only validity drops.
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            main_a_reg     <= main_a_next;
            main_b_reg     <= main_b_next;
            skid_valid_reg <= skid_valid_next;
            skid_a_reg     <= skid_a_next;
            skid_b_reg     <= skid_b_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign alu_a     = main_a_reg;
    assign alu_b     = main_b_reg;
    assign occupancy = {main_valid_reg & skid_valid_reg, main_valid_reg ^ skid_valid_reg};

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Self-checking bench for alu_operand_stage (DW=16, IMW=8). A queue-based
// model of the stage is stepped on every rising edge; all outputs are
// compared against it 1 ns after each edge. Directed scenarios add literal
// expectations, followed by a randomized run with occasional flush/rst.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam int DW  = 16;
    localparam int IMW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  rd_q;
    logic [DW-1:0]  rs_q;
    logic [IMW-1:0] offset;
    logic [1:0]     b_sel;
    logic           a_sel;
    logic [DW-1:0]  fwd_data;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     occupancy;

    int errors = 0;
    int checks = 0;
    bit verbose = 1'b1;

    alu_operand_stage #(.DW(DW), .IMW(IMW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_q      (rd_q),
        .rs_q      (rs_q),
        .offset    (offset),
        .b_sel     (b_sel),
        .a_sel     (a_sel),
        .fwd_data  (fwd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: an ordered queue of at most two operand pairs.
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    function automatic logic [DW-1:0] model_a(logic sel, logic [DW-1:0] rd, logic [DW-1:0] fwd);
`ifdef ALU_OPERAND_FWD_EN
        return sel ? fwd : rd;
`else
        return rd;
`endif
    endfunction

    function automatic logic [DW-1:0] model_b(logic [1:0] sel, logic [IMW-1:0] off,
                                              logic [DW-1:0] rs, logic [DW-1:0] fwd);
        longint v;
        v = longint'(off);
        if (sel == 2'd0) return DW'(v);
        if (sel == 2'd1) begin
            // Negative immediate: add the upper-bit fill 2^DW - 2^IMW.
            if (v >= (longint'(1) << (IMW - 1)))
                v = v + (longint'(1) << DW) - (longint'(1) << IMW);
            return DW'(v);
        end
`ifdef ALU_OPERAND_FWD_EN
        if (sel == 2'd3) return fwd;
`endif
        return rs;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs present at the edge,
    // then compare every DUT output against it.
    task automatic step();
        ent_t e;
        bit   do_in;
        bit   do_out;
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_a = '0;
            last_b = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            do_in  = in_valid && (q.size() < 2);
            do_out = (q.size() > 0) && out_ready;
            e.a = model_a(a_sel, rd_q, fwd_data);
            e.b = model_b(b_sel, offset, rs_q, fwd_data);
            if (do_out) begin
                if (verbose) $display("out: a=%h b=%h", q[0].a, q[0].b);
                void'(q.pop_front());
            end
            if (do_in) begin
                q.push_back(e);
                if (verbose) $display("in : a=%h b=%h", e.a, e.b);
            end
            if (q.size() > 0) begin
                last_a = q[0].a;
                last_b = q[0].b;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("occupancy", 32'(occupancy), 32'(q.size()));
        check("in_ready",  32'(in_ready),  32'(q.size() < 2));
        check("alu_a",     32'(alu_a),     32'(last_a));
        check("alu_b",     32'(alu_b),     32'(last_b));
    endtask

    task automatic set_req(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] rs,
                           input logic [IMW-1:0] off, input logic [1:0] bs, input logic as);
        in_valid = v;
        rd_q     = a;
        rs_q     = rs;
        offset   = off;
        b_sel    = bs;
        a_sel    = as;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_data = '0;
        set_req(1'b0, '0, '0, '0, 2'b00, 1'b0);
        #1;

        // Reset state
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        rst = 1'b0;

        // Sign extension
        out_ready = 1'b1;
        set_req(1'b1, 16'h0010, 16'h7777, 8'hF3, 2'b01, 1'b0);
        step();
        check("sext_alu_a", 32'(alu_a), 32'h0010);
        check("sext_alu_b", 32'(alu_b), 32'hFFF3);
        check("sext_valid", 32'(out_valid), 32'd1);

        // Zero extension (back-to-back with the previous one draining)
        set_req(1'b1, 16'h0010, 16'h7777, 8'hF3, 2'b00, 1'b0);
        step();
        check("zext_alu_b", 32'(alu_b), 32'h00F3);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("hold_alu_b",  32'(alu_b), 32'h00F3);

        // Backpressure: three back-to-back requests with out_ready low
        out_ready = 1'b0;
        set_req(1'b1, 16'd1, 16'd0, 8'd0, 2'b10, 1'b0);
        step();
        check("bp_occ1", 32'(occupancy), 32'd1);
        rd_q = 16'd2;
        step();
        check("bp_occ2",  32'(occupancy), 32'd2);
        check("bp_ready", 32'(in_ready),  32'd0);
        rd_q = 16'd3;
        step();
        check("bp_held_occ", 32'(occupancy), 32'd2);
        check("bp_head1",    32'(alu_a), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_head2", 32'(alu_a), 32'd2);
        step();
        check("bp_head3", 32'(alu_a), 32'd3);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with two held entries and a simultaneous request
        out_ready = 1'b0;
        set_req(1'b1, 16'hAAAA, 16'h1, 8'h0, 2'b10, 1'b0);
        step();
        rd_q = 16'hBBBB;
        step();
        check("fl_occ2", 32'(occupancy), 32'd2);
        flush = 1'b1;
        rd_q = 16'hCCCC;
        step();
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_occ",   32'(occupancy), 32'd0);
        check("fl_ready", 32'(in_ready),  32'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("fl_no_stale", 32'(out_valid), 32'd0);
        step();

        // Forwarding
        fwd_data = 16'hBEEF;
        set_req(1'b1, 16'h1234, 16'h5678, 8'h00, 2'b11, 1'b1);
        step();
`ifdef ALU_OPERAND_FWD_EN
        check("fwd_alu_a", 32'(alu_a), 32'hBEEF);
        check("fwd_alu_b", 32'(alu_b), 32'hBEEF);
`else
        check("fwd_alu_a", 32'(alu_a), 32'h1234);
        check("fwd_alu_b", 32'(alu_b), 32'h5678);
`endif
        in_valid = 1'b0;
        step();

        // Reset mid-operation with two held entries
        out_ready = 1'b0;
        set_req(1'b1, 16'h0F0F, 16'h2, 8'h0, 2'b10, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_occ",   32'(occupancy), 32'd0);
        check("mrst_ready", 32'(in_ready),  32'd1);
        check("mrst_alu_a", 32'(alu_a),     32'd0);
        check("mrst_alu_b", 32'(alu_b),     32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();

        // Randomized run
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            fwd_data  = DW'($urandom);
            set_req($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom),
                    IMW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
- REQ-001: Parameter DW, default 16: operand and result width in bits.
- REQ-002: Parameter IMW, default 8: immediate (offset) width in bits; legal range 1..DW.
- REQ-003: clk  input  1: the single clock; all state updates on its rising edge.
- REQ-004: rst  input  1: reset, synchronous and active-high.
- REQ-005: flush  input  1: discards all held operands when high, synchronous.
- REQ-006: in_valid  input  1: upstream presents an operand request.
- REQ-007: in_ready  output  1: stage can accept a request this cycle.
- REQ-008: rd_q  input  DW: destination-register read data, the A source.
- REQ-009: rs_q  input  DW: source-register read data.
- REQ-010: offset  input  IMW: instruction immediate.
- REQ-011: b_sel  input  2: B source select. 00 zero-extended offset; 01 sign-extended offset; 10 rs_q; 11 fwd_data.
- REQ-012: a_sel  input  1: A source select. 0 rd_q; 1 fwd_data.
- REQ-013: fwd_data  input  DW: forwarded ALU result.
- REQ-014: alu_a  output  DW: registered A operand.
- REQ-015: alu_b  output  DW: registered B operand.
- REQ-016: out_valid  output  1: alu_a and alu_b are valid.
- REQ-017: out_ready  input  1: the ALU consumes the operands this cycle.
- REQ-018: occupancy  output  2: number of held entries, 0..2.

Function
- REQ-019: A transfer in occurs when in_valid and in_ready are both high; a transfer out occurs when out_valid and out_ready are both high.
- REQ-020: The operands are resolved combinationally from the sources in REQ-011 and REQ-012 at the moment of transfer in, then stored.
- REQ-021: The stage is a two-entry skid buffer: a main output register plus one skid register.
- REQ-022: Latency is 1 cycle: data accepted in cycle N appears on alu_a and alu_b with out_valid high in cycle N+1 when the main register was empty or was drained in cycle N.
- REQ-023: When the main register is full and not drained while a transfer in occurs, the new entry goes to the skid register.
- REQ-024: When the main register drains and the skid register is full, the skid entry moves to the main register in the same edge.
- REQ-025: in_ready is registered, and equals NOT (skid register full).
- REQ-026: In-order delivery; no entry is ever dropped or duplicated except by flush or rst.
- REQ-027: Zero extension sets bits DW-1..IMW to 0; sign extension replicates offset[IMW-1]; when IMW equals DW both are the identity.
- REQ-028: A simultaneous transfer in and transfer out at occupancy 1 leaves occupancy at 1, with the new data in the main register.
- REQ-029: flush clears both entries in the next cycle: out_valid=0, occupancy=0, in_ready=1. A transfer in during a flush cycle is discarded.
- REQ-030: While out_valid is 0, alu_a and alu_b hold their last values.
- REQ-031: occupancy equals the number of full registers and is updated on the same edge as the entries.

Reset
- REQ-032: While rst is high at a clock edge: alu_a=0, alu_b=0, out_valid=0, occupancy=0, in_ready=1, skid register cleared.
- REQ-033: rst has priority over flush, and flush has priority over transfers.
- REQ-034: Reset mid-operation discards any held entries with no partial output.

Configuration
- REQ-035: Macro ALU_OPERAND_FWD_EN controls the forwarding path.
  - Defined: a_sel=1 and b_sel=11 select fwd_data.
  - Undefined: fwd_data is ignored, a_sel is treated as 0, and b_sel=11 behaves as 10 (rs_q).

Verification
- REQ-036: Sign extension: DW=16, IMW=8, b_sel=01, offset=8'hF3, rd_q=16'h0010, out_ready=1 -> next cycle alu_a=16'h0010, alu_b=16'hFFF3, out_valid=1.
- REQ-037: Zero extension: same stimulus with b_sel=00 -> alu_b=16'h00F3.
- REQ-038: Backpressure: out_ready=0, send three back-to-back requests A=1,2,3 -> occupancy goes 1 then 2; in_ready goes low after the second is accepted and the third is held off; raising out_ready delivers 1,2,3 in order.
- REQ-039: Flush: occupancy=2, then flush=1 for one cycle -> next cycle out_valid=0, occupancy=0, in_ready=1; no stale operand appears afterwards.
- REQ-040: Forwarding: with ALU_OPERAND_FWD_EN defined, a_sel=1, b_sel=11, fwd_data=16'hBEEF -> alu_a=alu_b=16'hBEEF; without the macro, the same stimulus gives alu_a=rd_q and alu_b=rs_q.
- REQ-041: Reset mid-operation: rst=1 for one cycle with occupancy=2 -> all outputs at their REQ-032 values the following cycle.
